// File: rtl/rice_core_execute_stage.sv
// rtl/rice_core_execute_stage.sv - rice core execute stage with operand/result registers and bypass taps
//
// Contents:
//   rice_core_pkg            ALU command/source encodings and the packed alu_operation bundle.
//   rice_core_alu            Combinational ALU. Operand 1 is rs1, pc or zero. Operand 2 is rs2 or imm.
//   rice_core_execute_stage  Two-register execute stage between decode and writeback.
//
// rice_core_execute_stage ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_flush                drop every in-flight instruction at the next edge
//   i_id_*  / o_id_ready   decode handshake and decoded payload (pc, operands, op, rd)
//   o_wb_*  / i_wb_ready   writeback handshake and result payload
//   o_fwd_ex_*             bypass tap from the operand stage (combinational ALU result)
//   o_fwd_wb_*             bypass tap from the result stage

package rice_core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } rice_core_alu_command;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } rice_core_alu_source_1;

    typedef enum logic [0:0] {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } rice_core_alu_source_2;

    // All-zero encodes ADD rs1+rs2, so a cleared operand register yields result 0.
    typedef struct packed {
        rice_core_alu_command  command;
        rice_core_alu_source_1 source_1;
        rice_core_alu_source_2 source_2;
    } rice_core_alu_operation;

endpackage

// Ports:
//   i_pc, i_rs1, i_rs2, i_imm  candidate operands
//   i_operation                command and operand selects
//   o_result                   XLEN-bit result
module rice_core_alu
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]        i_pc,
    input  logic [XLEN-1:0]        i_rs1,
    input  logic [XLEN-1:0]        i_rs2,
    input  logic [XLEN-1:0]        i_imm,
    input  rice_core_alu_operation i_operation,
    output logic [XLEN-1:0]        o_result
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  shamt;

    always_comb begin
        case (i_operation.source_1)
            SRC1_RS1: op1 = i_rs1;
            SRC1_PC:  op1 = i_pc;
            default:  op1 = '0;
        endcase

        op2 = (i_operation.source_2 == SRC2_IMM) ? i_imm : i_rs2;

        // Shift amount uses only the low log2(XLEN) bits of operand 2.
        shamt = op2[SHW-1:0];

        case (i_operation.command)
            ALU_ADD:  o_result = op1 + op2;
            ALU_SUB:  o_result = op1 - op2;
            ALU_SLL:  o_result = op1 << shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  o_result = op1 ^ op2;
            ALU_SRL:  o_result = op1 >> shamt;
            ALU_SRA:  o_result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   o_result = op1 | op2;
            ALU_AND:  o_result = op1 & op2;
            default:  o_result = '0;
        endcase
    end

endmodule

module rice_core_execute_stage
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,

    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [XLEN-1:0]        i_id_pc,
    input  logic [XLEN-1:0]        i_id_rs1_value,
    input  logic [XLEN-1:0]        i_id_rs2_value,
    input  logic [XLEN-1:0]        i_id_imm_value,
    input  rice_core_alu_operation i_id_alu_operation,
    input  logic [4:0]             i_id_rd,
    input  logic                   i_id_rd_write,

    output logic                   o_wb_valid,
    input  logic                   i_wb_ready,
    output logic [XLEN-1:0]        o_wb_pc,
    output logic [XLEN-1:0]        o_wb_result,
    output logic [4:0]             o_wb_rd,
    output logic                   o_wb_rd_write,

    output logic                   o_fwd_ex_valid,
    output logic [4:0]             o_fwd_ex_rd,
    output logic [XLEN-1:0]        o_fwd_ex_value,
    output logic                   o_fwd_wb_valid,
    output logic [4:0]             o_fwd_wb_rd,
    output logic [XLEN-1:0]        o_fwd_wb_value
);

    // Stage A: operand register
    logic                   a_valid_q;
    logic                   a_valid_d;
    logic [XLEN-1:0]        a_pc_q;
    logic [XLEN-1:0]        a_rs1_q;
    logic [XLEN-1:0]        a_rs2_q;
    logic [XLEN-1:0]        a_imm_q;
    rice_core_alu_operation a_op_q;
    logic [4:0]             a_rd_q;
    logic                   a_rd_write_q;

    // Stage B: result register
    logic                   b_valid_q;
    logic                   b_valid_d;
    logic [XLEN-1:0]        b_pc_q;
    logic [XLEN-1:0]        b_result_q;
    logic [4:0]             b_rd_q;
    logic                   b_rd_write_q;

    logic                   b_advance;
    logic                   a_advance;
    logic                   id_ready;
    logic                   id_accept;
    logic                   b_load;
    logic [XLEN-1:0]        alu_result;

    rice_core_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_pc        (a_pc_q),
        .i_rs1       (a_rs1_q),
        .i_rs2       (a_rs2_q),
        .i_imm       (a_imm_q),
        .i_operation (a_op_q),
        .o_result    (alu_result)
    );

    // i_wb_ready reaches o_id_ready combinationally through b_advance.
    // This lets a full pipe accept in the same cycle WB drains it, so
    // throughput stays at one per cycle.
    always_comb begin
        b_advance = !b_valid_q || i_wb_ready;
        a_advance = a_valid_q && b_advance;
        id_ready  = !i_flush && (!a_valid_q || b_advance);
        id_accept = i_id_valid && id_ready;
        // Flush wins over advance, so B's payload holds during a flush.
        b_load    = a_advance && !i_flush;

        a_valid_d = a_valid_q;
        if (i_flush) begin
            a_valid_d = 1'b0;
        end else if (id_accept) begin
            a_valid_d = 1'b1;
        end else if (a_advance) begin
            a_valid_d = 1'b0;
        end

        b_valid_d = b_valid_q;
        if (i_flush) begin
            b_valid_d = 1'b0;
        end else if (a_advance) begin
            b_valid_d = 1'b1;
        end else if (i_wb_ready && b_valid_q) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_valid_q    <= 1'b0;
            a_pc_q       <= '0;
            a_rs1_q      <= '0;
            a_rs2_q      <= '0;
            a_imm_q      <= '0;
            a_op_q       <= '0;
            a_rd_q       <= '0;
            a_rd_write_q <= 1'b0;
            b_valid_q    <= 1'b0;
            b_pc_q       <= '0;
            b_result_q   <= '0;
            b_rd_q       <= '0;
            b_rd_write_q <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;

            if (id_accept) begin
                a_pc_q       <= i_id_pc;
                a_rs1_q      <= i_id_rs1_value;
                a_rs2_q      <= i_id_rs2_value;
                a_imm_q      <= i_id_imm_value;
                a_op_q       <= i_id_alu_operation;
                a_rd_q       <= i_id_rd;
                // x0 is never written, so drop the write enable at capture.
                a_rd_write_q <= i_id_rd_write && (i_id_rd != 5'd0);
            end

            if (b_load) begin
                b_pc_q       <= a_pc_q;
                b_result_q   <= alu_result;
                b_rd_q       <= a_rd_q;
                b_rd_write_q <= a_rd_write_q;
            end
        end
    end

    assign o_id_ready     = id_ready;

    assign o_wb_valid     = b_valid_q;
    assign o_wb_pc        = b_pc_q;
    assign o_wb_result    = b_result_q;
    assign o_wb_rd        = b_rd_q;
    assign o_wb_rd_write  = b_rd_write_q;

    assign o_fwd_ex_valid = a_valid_q && a_rd_write_q;
    assign o_fwd_ex_rd    = a_rd_q;
    assign o_fwd_ex_value = alu_result;

    assign o_fwd_wb_valid = b_valid_q && b_rd_write_q;
    assign o_fwd_wb_rd    = b_rd_q;
    assign o_fwd_wb_value = b_result_q;

endmodule

// File: tb/tb_rice_core_execute_stage.sv
// tb/tb_rice_core_execute_stage.sv - randomized scoreboard bench for rice_core_execute_stage
module tb_rice_core_execute_stage;
    import rice_core_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   i_flush;
    logic                   i_id_valid;
    logic                   o_id_ready;
    logic [31:0]            i_id_pc;
    logic [31:0]            i_id_rs1_value;
    logic [31:0]            i_id_rs2_value;
    logic [31:0]            i_id_imm_value;
    rice_core_alu_operation i_id_alu_operation;
    logic [4:0]             i_id_rd;
    logic                   i_id_rd_write;
    logic                   o_wb_valid;
    logic                   i_wb_ready;
    logic [31:0]            o_wb_pc;
    logic [31:0]            o_wb_result;
    logic [4:0]             o_wb_rd;
    logic                   o_wb_rd_write;
    logic                   o_fwd_ex_valid;
    logic [4:0]             o_fwd_ex_rd;
    logic [31:0]            o_fwd_ex_value;
    logic                   o_fwd_wb_valid;
    logic [4:0]             o_fwd_wb_rd;
    logic [31:0]            o_fwd_wb_value;

    rice_core_execute_stage #(.XLEN(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_flush            (i_flush),
        .i_id_valid         (i_id_valid),
        .o_id_ready         (o_id_ready),
        .i_id_pc            (i_id_pc),
        .i_id_rs1_value     (i_id_rs1_value),
        .i_id_rs2_value     (i_id_rs2_value),
        .i_id_imm_value     (i_id_imm_value),
        .i_id_alu_operation (i_id_alu_operation),
        .i_id_rd            (i_id_rd),
        .i_id_rd_write      (i_id_rd_write),
        .o_wb_valid         (o_wb_valid),
        .i_wb_ready         (i_wb_ready),
        .o_wb_pc            (o_wb_pc),
        .o_wb_result        (o_wb_result),
        .o_wb_rd            (o_wb_rd),
        .o_wb_rd_write      (o_wb_rd_write),
        .o_fwd_ex_valid     (o_fwd_ex_valid),
        .o_fwd_ex_rd        (o_fwd_ex_rd),
        .o_fwd_ex_value     (o_fwd_ex_value),
        .o_fwd_wb_valid     (o_fwd_wb_valid),
        .o_fwd_wb_rd        (o_fwd_wb_rd),
        .o_fwd_wb_value     (o_fwd_wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   dut_takes;
    logic last_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ALU in plain arithmetic: shifts as multiply/divide by powers of two,
    // arithmetic right shift as floor division via the one's-complement identity.
    function automatic logic [31:0] ref_alu(input rice_core_alu_operation op,
                                            input logic [31:0] pc, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [31:0] imm);
        longint unsigned a;
        longint unsigned b;
        longint unsigned p;
        longint signed   sa;
        longint signed   sb;
        longint unsigned r;
        a = (op.source_1 == SRC1_RS1) ? 64'(rs1) : (op.source_1 == SRC1_PC) ? 64'(pc) : 64'd0;
        b = (op.source_2 == SRC2_IMM) ? 64'(imm) : 64'(rs2);
        p = 64'd1 << (b % 64'd32);
        sa = (a >= 64'h8000_0000) ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = (b >= 64'h8000_0000) ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        case (op.command)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a * p;
            ALU_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
            ALU_SLTU: r = (a < b) ? 64'd1 : 64'd0;
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a / p;
            ALU_SRA:  r = (sa < 0) ? ~((~a & 64'hFFFF_FFFF) / p) : a / p;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    // One clock: check all outputs against the scoreboard at the falling edge,
    // then retire/accept in the model after the rising edge.
    task automatic run_cycle();
        int          n;
        logic        exp_wbv;
        logic        exp_ready;
        logic        has_a;
        logic        do_acc;
        logic        do_take;
        exp_t        a_e;
        exp_t        ne;
        @(negedge clk);
        n = q.size();
        exp_wbv   = (n > 0) && (cyc >= q[0].acc + 1);
        has_a     = (n == 2) || ((n == 1) && !exp_wbv);
        a_e       = (n == 2) ? q[1] : ((n == 1) ? q[0] : '{32'd0, 32'd0, 5'd0, 1'b0, 0});
        exp_ready = !i_flush && ((n < 2) || i_wb_ready);

        check_eq("id_ready", 32'(o_id_ready), 32'(exp_ready));
        check_eq("wb_valid", 32'(o_wb_valid), 32'(exp_wbv));
        check_eq("fwd_wb_valid", 32'(o_fwd_wb_valid), 32'(exp_wbv && q[0].wr));
        check_eq("fwd_ex_valid", 32'(o_fwd_ex_valid), 32'(has_a && a_e.wr));
        if (exp_wbv) begin
            check_eq("wb_pc", o_wb_pc, q[0].pc);
            check_eq("wb_result", o_wb_result, q[0].res);
            check_eq("wb_rd", 32'(o_wb_rd), 32'(q[0].rd));
            check_eq("wb_rd_write", 32'(o_wb_rd_write), 32'(q[0].wr));
            check_eq("fwd_wb_rd", 32'(o_fwd_wb_rd), 32'(q[0].rd));
            check_eq("fwd_wb_value", o_fwd_wb_value, q[0].res);
        end
        if (has_a) begin
            check_eq("fwd_ex_rd", 32'(o_fwd_ex_rd), 32'(a_e.rd));
            check_eq("fwd_ex_value", o_fwd_ex_value, a_e.res);
        end

        if (o_wb_valid && i_wb_ready) dut_takes++;
        do_acc  = i_id_valid && exp_ready;
        do_take = exp_wbv && i_wb_ready;
        ne = '{i_id_pc, ref_alu(i_id_alu_operation, i_id_pc, i_id_rs1_value, i_id_rs2_value, i_id_imm_value),
               i_id_rd, i_id_rd_write && (i_id_rd != 5'd0), 0};
        last_acc = do_acc;

        @(posedge clk);
        #1;
        cyc++;
        if (do_take) void'(q.pop_front());
        if (i_flush) begin
            q.delete();
        end else if (do_acc) begin
            ne.acc = cyc;
            q.push_back(ne);
        end
    endtask

    task automatic set_op(input logic v, input rice_core_alu_command c,
                          input rice_core_alu_source_1 s1, input rice_core_alu_source_2 s2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic [4:0] rd, input logic wr);
        i_id_valid                  = v;
        i_id_alu_operation.command  = c;
        i_id_alu_operation.source_1 = s1;
        i_id_alu_operation.source_2 = s2;
        i_id_rs1_value              = r1;
        i_id_rs2_value              = r2;
        i_id_imm_value              = im;
        i_id_rd                     = rd;
        i_id_rd_write               = wr;
        i_id_pc                     = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic shift_case(input string tag, input rice_core_alu_command c,
                              input logic [31:0] r1, input logic [31:0] im, input logic [31:0] want);
        set_op(1'b1, c, SRC1_RS1, SRC2_IMM, r1, 32'd0, im, 5'd9, 1'b1);
        run_cycle();
        i_id_valid = 1'b0;
        run_cycle();
        check_eq(tag, o_wb_result, want);
        run_cycle();
    endtask

    initial begin
        int k;
        int guard;
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        dut_takes = 0;
        last_acc  = 1'b0;
        rst       = 1'b1;
        i_flush   = 1'b0;
        i_wb_ready = 1'b1;
        set_op(1'b0, ALU_ADD, SRC1_RS1, SRC2_RS2, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        i_id_pc   = 32'd0;

        // Reset state
        #2;
        check_eq("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        check_eq("rst_wb_result", o_wb_result, 32'd0);
        check_eq("rst_wb_pc", o_wb_pc, 32'd0);
        check_eq("rst_fwd_ex_value", o_fwd_ex_value, 32'd0);
        check_eq("rst_fwd_valid", 32'({o_fwd_ex_valid, o_fwd_wb_valid}), 32'd0);
        check_eq("rst_id_ready", 32'(o_id_ready), 32'd1);
        i_flush = 1'b1;
        #1;
        check_eq("rst_id_ready_flush", 32'(o_id_ready), 32'd0);
        i_flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD 5+7 -> 12, two cycles after accept
        set_op(1'b1, ALU_ADD, SRC1_RS1, SRC2_RS2, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1);
        run_cycle();
        i_id_valid = 1'b0;
        check_eq("add_fwd_ex_value", o_fwd_ex_value, 32'd12);
        check_eq("add_wb_not_yet", 32'(o_wb_valid), 32'd0);
        run_cycle();
        check_eq("add_wb_valid", 32'(o_wb_valid), 32'd1);
        check_eq("add_wb_result", o_wb_result, 32'd12);
        check_eq("add_wb_rd", 32'(o_wb_rd), 32'd3);
        run_cycle();

        // Back-pressure: 4 ADDI, WB stalled for 3 cycles
        dut_takes  = 0;
        i_wb_ready = 1'b0;
        k = 1;
        guard = 0;
        while (k <= 4 && guard < 20) begin
            set_op(1'b1, ALU_ADD, SRC1_RS1, SRC2_IMM, 32'd0, 32'd0, 32'(k), 5'(k), 1'b1);
            #1;
            if (guard == 2) begin
                check_eq("bp_id_ready_low", 32'(o_id_ready), 32'd0);
                check_eq("bp_wb_hold", o_wb_result, 32'd1);
            end
            if (guard == 3) i_wb_ready = 1'b1;
            run_cycle();
            if (last_acc) k++;
            guard++;
        end
        check_eq("bp_all_accepted", 32'(k), 32'd5);
        i_id_valid = 1'b0;
        repeat (4) run_cycle();
        check_eq("bp_takes", 32'(dut_takes), 32'd4);

        // Shifts
        shift_case("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        shift_case("sll", ALU_SLL, 32'h8000_0000, 32'd4, 32'h0000_0000);
        shift_case("srl", ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001);

        // rd = 0 never writes or forwards
        set_op(1'b1, ALU_ADD, SRC1_RS1, SRC2_RS2, 32'd1, 32'd2, 32'd0, 5'd0, 1'b1);
        run_cycle();
        i_id_valid = 1'b0;
        check_eq("rd0_fwd_ex_valid", 32'(o_fwd_ex_valid), 32'd0);
        run_cycle();
        check_eq("rd0_wb_valid", 32'(o_wb_valid), 32'd1);
        check_eq("rd0_wb_rd_write", 32'(o_wb_rd_write), 32'd0);
        check_eq("rd0_fwd_wb_valid", 32'(o_fwd_wb_valid), 32'd0);
        run_cycle();

        // Flush with both stages full and WB stalled
        i_wb_ready = 1'b0;
        set_op(1'b1, ALU_ADD, SRC1_RS1, SRC2_RS2, 32'd1, 32'd1, 32'd0, 5'd4, 1'b1);
        run_cycle();
        set_op(1'b1, ALU_ADD, SRC1_RS1, SRC2_RS2, 32'd2, 32'd2, 32'd0, 5'd5, 1'b1);
        run_cycle();
        i_flush = 1'b1;
        #1;
        check_eq("flush_id_ready", 32'(o_id_ready), 32'd0);
        run_cycle();
        check_eq("flush_wb_valid", 32'(o_wb_valid), 32'd0);
        check_eq("flush_fwd_ex_valid", 32'(o_fwd_ex_valid), 32'd0);
        i_flush    = 1'b0;
        i_wb_ready = 1'b1;
        set_op(1'b1, ALU_SUB, SRC1_RS1, SRC2_RS2, 32'd10, 32'd3, 32'd0, 5'd6, 1'b1);
        run_cycle();
        i_id_valid = 1'b0;
        run_cycle();
        check_eq("flush_sub_result", o_wb_result, 32'd7);
        run_cycle();

        // Asynchronous reset with both stages full
        i_wb_ready = 1'b0;
        set_op(1'b1, ALU_OR, SRC1_RS1, SRC2_RS2, 32'hF0, 32'h0F, 32'd0, 5'd7, 1'b1);
        run_cycle();
        set_op(1'b1, ALU_XOR, SRC1_RS1, SRC2_RS2, 32'hFF, 32'h0F, 32'd0, 5'd8, 1'b1);
        run_cycle();
        i_id_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_wb_valid", 32'(o_wb_valid), 32'd0);
        check_eq("arst_fwd_valid", 32'({o_fwd_ex_valid, o_fwd_wb_valid}), 32'd0);
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        i_wb_ready = 1'b1;
        repeat (3) run_cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_op(($urandom_range(0, 9) < 7),
                   rice_core_alu_command'(4'($urandom_range(0, 9))),
                   rice_core_alu_source_1'(2'($urandom_range(0, 2))),
                   rice_core_alu_source_2'(1'($urandom_range(0, 1))),
                   $urandom, $urandom,
                   ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            i_wb_ready = ($urandom_range(0, 9) < 7);
            i_flush    = ($urandom_range(0, 99) < 4);
            run_cycle();
        end
        i_flush    = 1'b0;
        i_id_valid = 1'b0;
        i_wb_ready = 1'b1;
        repeat (4) run_cycle();
        check_eq("drain_empty", 32'(o_wb_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
